// File: rtl/data_memory_jin.sv
// Word-organised data memory with byte addressing, combinational gated read
// and asynchronous clear. Words live in individual registers so the whole
// array can be cleared on Reset without waiting for a clock edge.
module data_memory_jin #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData
);

  localparam int IdxW = $clog2(DEPTH);

  logic [IdxW-1:0] wordIdx;
  logic            inRange;
  logic [31:0]     memWords [DEPTH];

  // The two low address bits select a byte within a word; they carry no
  // meaning here because every access is a full aligned word.
  logic [1:0]      unusedByteOffset;
  assign unusedByteOffset = Address[1:0];

  assign wordIdx = Address[IdxW+1:2];

  // Anything above the index field must be zero, otherwise the access would
  // silently alias onto a lower word.
  generate
    if (ADDR_W > IdxW + 2) begin : gUpperBits
      assign inRange = ~|Address[ADDR_W-1:IdxW+2];
    end else begin : gNoUpperBits
      assign inRange = 1'b1;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gWord
      logic [31:0] wordReg;

      // Each word clears on Reset and loads only when it is the addressed,
      // in-range target of a write.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          wordReg <= '0;
        end else if (MemWrite && inRange && (wordIdx == IdxW'(gi))) begin
          wordReg <= WriteData;
        end
      end

      assign memWords[gi] = wordReg;
    end
  endgenerate

  // Zero-latency read: the current stored word leaves the edge untouched, so
  // a same-cycle write shows the old value until the clock edge.
  always_comb begin
    ReadData = '0;
    if (MemRead && inRange && !Reset) begin
      ReadData = memWords[wordIdx];
    end
  end

endmodule

// File: tb/tb_data_memory_jin.sv
module tb_data_memory_jin;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int BYTES  = DEPTH * 4;

  logic              Clk;
  logic              Reset;
  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;

  int compared   = 0;
  int mismatched = 0;

  // Reference contents: plain array of words indexed by byte address / 4.
  logic [31:0] model [DEPTH];

  data_memory_jin #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .Address(Address),
    .WriteData(WriteData),
    .ReadData(ReadData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] expectedRead(input logic rd, input logic [31:0] addr,
                                               input logic rst);
    if (!rd || rst || addr >= BYTES) return 32'h0;
    return model[addr / 4];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRead(input string tag);
    check(tag, ReadData, expectedRead(MemRead, Address, Reset));
    $display("%-10s t=%0t we=%0b rd=%0b rst=%0b addr=%h wd=%h rdata=%h", tag, $time,
             MemWrite, MemRead, Reset, Address, WriteData, ReadData);
  endtask

  task automatic drive(input logic we, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd);
    MemWrite  = we;
    MemRead   = rd;
    Address   = addr;
    WriteData = wd;
  endtask

  // Advance past one rising edge and apply the write it performed to the model.
  task automatic clockEdge();
    @(posedge Clk);
    if (MemWrite && !Reset && Address < BYTES) model[Address / 4] = WriteData;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] addr;
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    Reset = 1'b0;
    clearModel();

    // Reset pulse; read must be zero while held.
    #2 Reset = 1'b1;
    #1 checkRead("rst_hold");
    @(posedge Clk); #3;
    Reset = 1'b0;
    @(negedge Clk);

    // Basic write/read-back.
    drive(1'b1, 1'b0, 32'd0, 32'h0000FFFF); clockEdge();
    drive(1'b1, 1'b0, 32'd4, 32'h0000EEEE); clockEdge();
    drive(1'b1, 1'b0, 32'd8, 32'h0000DDDD); clockEdge();
    drive(1'b0, 1'b1, 32'd0, 32'h1111); #1 check("rb0", ReadData, 32'h0000FFFF); clockEdge();
    drive(1'b0, 1'b1, 32'd4, 32'h2222); #1 check("rb4", ReadData, 32'h0000EEEE); clockEdge();
    drive(1'b0, 1'b1, 32'd8, 32'h3333); #1 check("rb8", ReadData, 32'h0000DDDD); clockEdge();
    check("rb8_kept", ReadData, 32'h0000DDDD);

    // Read gating and byte offset.
    drive(1'b0, 1'b0, 32'd4, 32'h0); #1 check("gate_off", ReadData, 32'h0);
    drive(1'b0, 1'b1, 32'd5, 32'h0); #1 check("byte_off", ReadData, 32'h0000EEEE);

    // Bounds.
    drive(1'b1, 1'b0, 32'd256, 32'hDEADBEEF); clockEdge();
    drive(1'b0, 1'b1, 32'd256, 32'h0); #1 check("oob_read", ReadData, 32'h0);
    drive(1'b0, 1'b1, 32'd0, 32'h0);   #1 check("no_alias", ReadData, 32'h0000FFFF);
    drive(1'b1, 1'b0, 32'd252, 32'hDEADBEEF); clockEdge();
    drive(1'b0, 1'b1, 32'd252, 32'h0); #1 check("top_word", ReadData, 32'hDEADBEEF);

    // Same-cycle write/read shows old word until the edge.
    @(negedge Clk);
    drive(1'b1, 1'b1, 32'd8, 32'h12345678); #1 check("rbw_old", ReadData, 32'h0000DDDD);
    clockEdge();
    drive(1'b0, 1'b1, 32'd8, 32'h0); #1 check("rbw_new", ReadData, 32'h12345678);

    // Mid-cycle reset discards a pending write and clears immediately.
    @(negedge Clk);
    drive(1'b1, 1'b1, 32'd8, 32'hCAFEF00D);
    #1 Reset = 1'b1;
    clearModel();
    #1 check("rst_mid", ReadData, 32'h0);
    clockEdge();
    check("rst_blk", ReadData, 32'h0);
    drive(1'b0, 1'b1, 32'd8, 32'h0);
    #1 Reset = 1'b0;
    for (int a = 0; a <= 8; a += 4) begin
      drive(1'b0, 1'b1, a, 32'h0); #1 check("post_rst", ReadData, 32'h0);
    end
    // First write after release lands normally.
    drive(1'b1, 1'b0, 32'd12, 32'hA5A5A5A5); clockEdge();
    drive(1'b0, 1'b1, 32'd12, 32'h0); #1 check("first_wr", ReadData, 32'hA5A5A5A5);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      case ($urandom_range(0, 3))
        0:       addr = 32'(BYTES) + $urandom_range(0, 1023);
        1:       addr = $urandom;
        default: addr = $urandom_range(0, BYTES - 1);
      endcase
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), addr, $urandom);
      #1 checkRead("rnd_pre");
      clockEdge();
      checkRead("rnd_post");
    end

    // Full sweep catches any stray or aliased write.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4 + (i % 4)), $urandom);
      #1 checkRead("sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_jin.md
DATA_MEMORY_JIN -- requirements
Module: data_memory_jin

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter ADDR_W, default 32: width of the Address port.
REQ-003 Clk  input  1: the single clock; all writes occur on its rising edge.
REQ-004 Reset  input  1: asynchronous, active-high reset.
REQ-005 MemWrite  input  1: write enable, sampled at the rising edge of Clk.
REQ-006 MemRead  input  1: read enable; gates ReadData combinationally.
REQ-007 Address  input  ADDR_W: byte address.
REQ-008 WriteData  input  32: data to be stored.
REQ-009 ReadData  output  32: data read from memory.

Function
REQ-010 The memory SHALL be organised as DEPTH words of 32 bits each, word-addressed by byte address.
REQ-011 Word index SHALL be Address[log2(DEPTH)+1:2].
- Address[1:0] ignored: no byte lanes, no misalignment fault.
REQ-012 An address is in range when Address[ADDR_W-1:log2(DEPTH)+2] is zero; all other addresses are out of range.
REQ-013 When MemWrite=1 at a rising edge of Clk, Reset=0 and the address is in range, mem[index] SHALL take the value of WriteData.
REQ-014 An out-of-range write SHALL be ignored: no word changes, including no aliasing to a lower index.
REQ-015 When MemWrite=0, no word SHALL change at the rising edge.
REQ-016 When MemRead=1 and the address is in range, ReadData SHALL equal mem[index] combinationally: zero-cycle latency, no clock needed.
REQ-017 When MemRead=1 and the address is out of range, ReadData SHALL be 32'h0.
REQ-018 When MemRead=0, ReadData SHALL be 32'h0.
REQ-019 When MemRead=1 and MemWrite=1 to the same index, ReadData SHALL show the old word until the edge, then the new word after it (read-before-write within a cycle).
REQ-020 Values of WriteData SHALL be ignored whenever MemWrite=0.
REQ-021 Every word SHALL retain its value indefinitely between writes.
REQ-022 No output may be X or Z after the first reset.

Reset
REQ-023 While Reset=1, every memory word SHALL be 32'h0, cleared asynchronously without waiting for a clock edge.
REQ-024 While Reset=1, writes SHALL be blocked.
REQ-025 While Reset=1, ReadData SHALL be 32'h0.
REQ-026 A Reset asserted between clock edges SHALL discard any pending write that has not yet reached an edge.
REQ-027 After Reset deasserts, the first rising edge of Clk with MemWrite=1 SHALL perform a write normally.

Verification
REQ-028 Basic write/read-back: pulse Reset; write 0x0000FFFF@0, 0x0000EEEE@4, 0x0000DDDD@8 on successive edges; then MemRead=1 at 0, 4, 8 with WriteData=0x1111/0x2222/0x3333 and MemWrite=0 -> ReadData = 0x0000FFFF, 0x0000EEEE, 0x0000DDDD; no words modified.
REQ-029 Read gating and byte offset:
- MemRead=0 at Address=4 after the write above -> ReadData=0.
- MemRead=1 at Address=5 -> ReadData=0x0000EEEE.
REQ-030 Bounds (DEPTH=64):
- Write 0xDEADBEEF@256 -> ignored.
- Read@256 -> ReadData=0.
- Read@0 -> ReadData unchanged at 0x0000FFFF.
- Write@252, read@252 -> 0xDEADBEEF.
REQ-031 Same-cycle write/read: MemRead=1, MemWrite=1 at Address=8, WriteData=0x12345678 -> ReadData=0x0000DDDD before the edge and 0x12345678 after it.
REQ-032 Mid-operation reset: assert Reset between edges after the writes above -> ReadData=0 immediately; after release, reads at 0, 4 and 8 -> 0.
